// File: rtl/lfsr_cipher_pkg.sv
// Shared types and constants for the LFSR stream-cipher controller.
package lfsr_cipher_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StPre,
        StData,
        StDrain
    } cipher_state_e;

    localparam int unsigned DEFAULT_PREAMBLE_LEN  = 7;
    localparam logic [7:0]  DEFAULT_PREAMBLE_CHAR = 8'h5F;
    localparam logic [31:0] SEED_ZERO_SUB         = 32'h0000_0001;

endpackage

// File: rtl/lfsr_cipher_ctrl.sv
// Seeds and steps an external LFSR and XORs a preamble plus payload bytes with its low byte.
module lfsr_cipher_ctrl
    import lfsr_cipher_pkg::*;
#(
    parameter int unsigned PREAMBLE_LEN  = DEFAULT_PREAMBLE_LEN,
    parameter logic [7:0]  PREAMBLE_CHAR = DEFAULT_PREAMBLE_CHAR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] seed,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_byte,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic        out_last,
    output logic        lfsr_ld,
    output logic [31:0] lfsr_ld_val,
    output logic        lfsr_step,
    input  logic [31:0] lfsr_val,
    output logic        busy
);

    localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);

    cipher_state_e state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          out_valid_q, out_valid_d;
    logic [7:0]    out_byte_q, out_byte_d;
    logic          out_last_q, out_last_d;
    logic [31:0]   ld_val_q, ld_val_d;

    logic          slot_free;
    logic          emit;
    logic [7:0]    src_byte;
    logic          src_last;
    logic          unused_lfsr_hi;

    assign unused_lfsr_hi = ^lfsr_val[31:8];
    assign slot_free      = !out_valid_q || out_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ld_val_d    = ld_val_q;
        out_byte_d  = out_byte_q;
        out_last_d  = out_last_q;
        // A consumed byte frees the register unless a new emit refills it below.
        out_valid_d = out_valid_q && !out_ready;
        emit        = 1'b0;
        src_byte    = PREAMBLE_CHAR;
        src_last    = 1'b0;
        in_ready    = 1'b0;
        lfsr_ld     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    ld_val_d = (seed == 32'h0) ? SEED_ZERO_SUB : seed;
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                lfsr_ld = 1'b1;
                cnt_d   = 8'h00;
                state_d = StPre;
            end
            StPre: begin
                if (slot_free) begin
                    emit  = 1'b1;
                    cnt_d = cnt_q + 8'h01;
                    if (cnt_q == PRE_LAST) begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                in_ready = slot_free;
                if (in_valid && slot_free) begin
                    emit     = 1'b1;
                    src_byte = in_byte;
                    src_last = in_last;
                    if (in_last) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (out_valid_q && out_ready && out_last_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (emit) begin
            out_valid_d = 1'b1;
            out_byte_d  = src_byte ^ lfsr_val[7:0];
            out_last_d  = src_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 8'h00;
            ld_val_q    <= 32'h0;
            out_valid_q <= 1'b0;
            out_byte_q  <= 8'h00;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ld_val_q    <= ld_val_d;
            out_valid_q <= out_valid_d;
            out_byte_q  <= out_byte_d;
            out_last_q  <= out_last_d;
        end
    end

    assign lfsr_step   = emit;
    assign lfsr_ld_val = ld_val_q;
    assign out_valid   = out_valid_q;
    assign out_byte    = out_byte_q;
    assign out_last    = out_last_q;
    assign busy        = (state_q != StIdle);

endmodule
